memory_arbiter: RTL
===================

# memory_arbiter

Two-port, single-outstanding-request arbiter between the instruction-cache refill port and the core data port, in front of the unified single-port main memory. It replaces the ad-hoc wait counter at the top level with a real request/ready handshake on both sides and a configurable fixed memory latency. It provides round-robin fairness on simultaneous requests and exposes per-port grant counters for performance observation.

## Interface
- LATENCY, 2: cycles the granted access spends in BUSY; legal range is LATENCY >= 2.
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- i_request  in  1  instruction refill request; held with i_address until i_ready
- i_address  in  32  instruction word address (byte address, word aligned)
- i_ready  out  1  one-cycle pulse; i_read_data valid in the same cycle
- i_read_data  out  32  returned instruction word
- d_request  in  1  data request; held with d_* inputs until d_ready
- d_write_enable  in  1  1 = write, 0 = read
- d_byte_enable  in  4  write byte lanes
- d_address  in  32  data byte address
- d_write_data  in  32  write data
- d_ready  out  1  one-cycle pulse marking completion
- d_read_data  out  32  read data; for writes, the pre-write word
- mem_address  out  32  registered address to main memory
- mem_write_enable  out  1  write strobe to memory
- mem_byte_enable  out  4  byte lanes to memory
- mem_write_data  out  32  write data to memory
- mem_read_data  in  32  synchronous read data, valid one cycle after mem_address
- i_grant_count  out  32  completed instruction transactions, wrapping
- d_grant_count  out  32  completed data transactions, wrapping

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - On a single request, grant that port.
  - If both ports request in the same cycle, grant the port not recorded in last_grant.
  - On grant:
    - latch the port id;
    - register mem_address and, for a data request, mem_byte_enable and mem_write_data;
    - load wait counter = LATENCY-1;
    - go to BUSY.
- **BUSY**
  - Hold all mem_* outputs stable with mem_write_enable = 0.
  - Decrement the counter each cycle.
  - In the cycle the counter is 0: capture mem_read_data into the granted port's read_data register, then go to DONE.
- **DONE**
  - Assert the granted port's ready for exactly one cycle.
  - If the granted request is a data write, assert mem_write_enable = 1 for this cycle only.
  - Increment that port's grant counter.
  - Update last_grant to the port just served.
  - Go to IDLE.
- The ungranted port's request stays pending and is untouched. Its read_data register holds its previous value.
- Requester rule: deassert the request, or present a new one, in the cycle after ready. The arbiter never re-samples a request in DONE.
- Request inputs are sampled only in IDLE. Changes during BUSY or DONE are ignored.
- Grant counters wrap from 0xFFFFFFFF to 0.

## Timing
- Request first high in IDLE cycle 0 → BUSY occupies cycles 1..LATENCY → ready high in cycle LATENCY+1 → IDLE in cycle LATENCY+2.
- Back-to-back throughput: one transaction per LATENCY+2 cycles.
- mem_address is valid from cycle 1. Read data is captured at the end of cycle LATENCY, which is why LATENCY >= 2 is required.
- Reset values: state IDLE, last_grant = data (so instruction wins the first tie), i_ready 0, d_ready 0, i_read_data 0, d_read_data 0, mem_address 0, mem_write_enable 0, mem_byte_enable 0, mem_write_data 0, both counters 0.
- Reset asserted mid-transaction:
  - return to IDLE immediately;
  - abandon the transaction with no ready pulse and no memory write;
  - requesters re-issue after reset.
- Simultaneous requests with a transaction in flight: no effect until IDLE.
- Worst-case wait for the losing port is one full transaction.

## Test plan
- **Single instruction read.** LATENCY = 2, memory word 0x10 = 0xDEADBEEF, i_request with i_address = 0x10 in cycle 0 → i_ready only in cycle 3 with i_read_data = 0xDEADBEEF; i_grant_count = 1; d_ready never asserts.
- **Data write then read.** d_write_enable = 1, byte enable 4'b0011, write 0x12345678 to address 0x40, which holds 0xAABBCCDD → mem_write_enable high only in the DONE cycle; d_read_data = 0xAABBCCDD. A following read of 0x40 → 0xAABB5678.
- **Simultaneous requests after reset.** Both ports request at cycle 0 → instruction is served first (ready at cycle 3), then data (ready at cycle 7). Repeating the tie → data first, then instruction.
- **Long stream.** Keep i_request high and d_request off for 100 refills → every i_ready is exactly LATENCY+2 cycles apart; i_grant_count = 100. Counter wrap is checked with a forced 0xFFFFFFFF preload → increments to 0.
- **Reset mid-write.** Drop rst_n in BUSY of a data write → no mem_write_enable pulse; memory contents unchanged; all outputs at reset values; the re-issued request completes normally.
- **LATENCY = 5 build.** An instruction read returns ready at cycle 6 with correct data; request changes during BUSY do not alter mem_address.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Bundle of the requester-side and memory-side signals of the memory arbiter.
// The arbiter connects through the slave modport; requesters and the main
// memory sit on the master side.
interface memory_arbiter_if;
    logic        i_request;
    logic [31:0] i_address;
    logic        i_ready;
    logic [31:0] i_read_data;

    logic        d_request;
    logic        d_write_enable;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_address;
    logic [31:0] d_write_data;
    logic        d_ready;
    logic [31:0] d_read_data;

    logic [31:0] mem_address;
    logic        mem_write_enable;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] i_grant_count;
    logic [31:0] d_grant_count;

    modport slave (
        input  i_request, i_address,
        input  d_request, d_write_enable, d_byte_enable, d_address, d_write_data,
        input  mem_read_data,
        output i_ready, i_read_data,
        output d_ready, d_read_data,
        output mem_address, mem_write_enable, mem_byte_enable, mem_write_data,
        output i_grant_count, d_grant_count
    );

    modport master (
        output i_request, i_address,
        output d_request, d_write_enable, d_byte_enable, d_address, d_write_data,
        output mem_read_data,
        input  i_ready, i_read_data,
        input  d_ready, d_read_data,
        input  mem_address, mem_write_enable, mem_byte_enable, mem_write_data,
        input  i_grant_count, d_grant_count
    );
endinterface

// File: rtl/memory_arbiter.sv
// Single-outstanding-request arbiter between the instruction refill port and
// the core data port in front of the single-port main memory. Simultaneous
// requests alternate between ports; each access spends LATENCY cycles in
// BUSY, completes with a one-cycle ready pulse, and writes commit to memory
// only in that completion cycle so the pre-write word can be returned.
module memory_arbiter #(
    parameter int LATENCY = 2
) (
    input logic             clk,
    input logic             rst_n,
    memory_arbiter_if.slave bus
);
    // Wide enough to hold LATENCY-1 for every LATENCY >= 2.
    localparam int CW = $clog2(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_grantData;
    logic          r_lastGrantData;
    logic          r_isWrite;
    logic [CW-1:0] r_waitCount;

    logic          r_iReady;
    logic          r_dReady;
    logic [31:0]   r_iReadData;
    logic [31:0]   r_dReadData;
    logic [31:0]   r_memAddress;
    logic          r_memWriteEnable;
    logic [3:0]    r_memByteEnable;
    logic [31:0]   r_memWriteData;
    logic [31:0]   r_iGrantCount;
    logic [31:0]   r_dGrantCount;

    logic          w_anyRequest;
    logic          w_pickData;

    // On a tie the port that was not served last wins.
    assign w_anyRequest = bus.i_request | bus.d_request;
    assign w_pickData   = bus.d_request & (~bus.i_request | ~r_lastGrantData);

    assign bus.i_ready          = r_iReady;
    assign bus.i_read_data      = r_iReadData;
    assign bus.d_ready          = r_dReady;
    assign bus.d_read_data      = r_dReadData;
    assign bus.mem_address      = r_memAddress;
    assign bus.mem_write_enable = r_memWriteEnable;
    assign bus.mem_byte_enable  = r_memByteEnable;
    assign bus.mem_write_data   = r_memWriteData;
    assign bus.i_grant_count    = r_iGrantCount;
    assign bus.d_grant_count    = r_dGrantCount;

    // Arbitration FSM with all outputs registered; reset abandons any access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_grantData      <= 1'b0;
            r_lastGrantData  <= 1'b1;
            r_isWrite        <= 1'b0;
            r_waitCount      <= '0;
            r_iReady         <= 1'b0;
            r_dReady         <= 1'b0;
            r_iReadData      <= '0;
            r_dReadData      <= '0;
            r_memAddress     <= '0;
            r_memWriteEnable <= 1'b0;
            r_memByteEnable  <= '0;
            r_memWriteData   <= '0;
            r_iGrantCount    <= '0;
            r_dGrantCount    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyRequest) begin
                        r_grantData <= w_pickData;
                        if (w_pickData) begin
                            r_memAddress    <= bus.d_address;
                            r_memByteEnable <= bus.d_byte_enable;
                            r_memWriteData  <= bus.d_write_data;
                            r_isWrite       <= bus.d_write_enable;
                        end else begin
                            r_memAddress    <= bus.i_address;
                            r_isWrite       <= 1'b0;
                        end
                        r_waitCount <= CW'(LATENCY - 1);
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_waitCount == '0) begin
                        if (r_grantData) begin
                            r_dReadData <= bus.mem_read_data;
                            r_dReady    <= 1'b1;
                        end else begin
                            r_iReadData <= bus.mem_read_data;
                            r_iReady    <= 1'b1;
                        end
                        r_memWriteEnable <= r_isWrite;
                        r_state          <= DONE;
                    end else begin
                        r_waitCount <= r_waitCount - 1'b1;
                    end
                end
                DONE: begin
                    r_iReady         <= 1'b0;
                    r_dReady         <= 1'b0;
                    r_memWriteEnable <= 1'b0;
                    if (r_grantData) begin
                        r_dGrantCount <= r_dGrantCount + 32'd1;
                    end else begin
                        r_iGrantCount <= r_iGrantCount + 32'd1;
                    end
                    r_lastGrantData <= r_grantData;
                    r_state         <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
